detector_jogada: RTL
====================

DETECTOR_JOGADA -- requirements
Module: detector_jogada

Interface
REQ-001 SHALL have parameter DEBOUNCE_CICLOS, default 4, meaning consecutive stable synchronized cycles required to accept a press or release (minimum 1).
REQ-002 SHALL have parameter TIMEOUT_CICLOS, default 5000, meaning counting cycles until timeout asserts (minimum 2).
REQ-003 SHALL have port clock  input  1  system clock, rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port botoes  input  4  raw asynchronous player buttons, active-high.
REQ-006 SHALL have port habilita_timeout  input  1  timeout counter enable, level, driven by the game control unit.
REQ-007 SHALL have port zera_timeout  input  1  synchronous clear of the timeout counter and flag.
REQ-008 SHALL have port jogada  output  1  one-cycle pulse, valid one-hot press accepted.
REQ-009 SHALL have port jogada_codigo  output  4  one-hot code of the last accepted press.
REQ-010 SHALL have port timeout  output  1  sticky timeout flag.
REQ-011 SHALL have port db_estado  output  2  current FSM state encoding, for debug.

Function
REQ-012 SHALL pass botoes through a two-flop synchronizer; all logic uses the synchronized value botoes_s.
REQ-013 SHALL implement FSM states OCIOSO=0, FILTRA=1, PULSO=2, SOLTA=3, with db_estado equal to the state code.
REQ-014 SHALL, in OCIOSO with botoes_s!=0, latch candidato<=botoes_s, clear the debounce counter and go to FILTRA.
REQ-015 SHALL, in FILTRA, return to OCIOSO when botoes_s!=candidato, otherwise increment the debounce counter.
REQ-016 SHALL, once FILTRA has seen DEBOUNCE_CICLOS consecutive matching cycles, go to PULSO if candidato is one-hot, else go to SOLTA with no pulse.
REQ-017 SHALL, in PULSO, assert jogada for exactly one cycle, load jogada_codigo<=candidato, and go to SOLTA.
REQ-018 SHALL, in SOLTA, leave for OCIOSO only after DEBOUNCE_CICLOS consecutive cycles with botoes_s==0, restarting the count on any nonzero sample.
REQ-019 SHALL hold jogada_codigo until the next accepted press or reset.
REQ-020 SHALL give latency DEBOUNCE_CICLOS+3 rising edges from a stable press at botoes to jogada high.
REQ-021 SHALL increment the timeout counter each cycle habilita_timeout=1 and timeout=0, and hold it otherwise.
REQ-022 SHALL set timeout on the counting cycle where the counter equals TIMEOUT_CICLOS-1, and hold it until zera_timeout or reset.
REQ-023 SHALL clear the counter on zera_timeout, or on jogada=1, with zera_timeout also clearing timeout.
REQ-024 SHALL give precedence to clearing when a clear coincides with the terminal count, so timeout stays 0.
REQ-025 SHALL give the debounce counter and timeout counter a width of clog2 of the respective parameter, with no wrap-around beyond the terminal value.

Reset
REQ-026 SHALL, on reset, force state OCIOSO, synchronizer flops 0, candidato 0, both counters 0, jogada 0, jogada_codigo 0, timeout 0, and db_estado 0.
REQ-027 SHALL, on reset mid-press, resume from OCIOSO and require a full debounce of any still-held button before it can pulse.

Configuration
REQ-028 SHALL, with macro DETECTOR_JOGADA_TIMEOUT_EN defined, implement REQ-021 to REQ-024.
REQ-029 SHALL, with DETECTOR_JOGADA_TIMEOUT_EN undefined, omit the timeout counter, tie timeout to 0, and ignore habilita_timeout and zera_timeout.

Verification (DEBOUNCE_CICLOS=4, TIMEOUT_CICLOS=20, macro defined)
REQ-030 SHALL cover: botoes=4'b0100 held 12 cycles -> exactly one jogada pulse at edge 7 after application, jogada_codigo=4'b0100, db_estado sequence 0,1,2,3.
REQ-031 SHALL cover: botoes=4'b0010 with 2-cycle glitches to 0 every 3 cycles -> no jogada and jogada_codigo unchanged.
REQ-032 SHALL cover: botoes=4'b0011 held 10 cycles then released -> no jogada, FSM passes 1->3->0, and jogada_codigo holds its prior value.
REQ-033 SHALL cover: habilita_timeout=1 and no press -> timeout rises on the 20th enabled cycle and stays 1; zera_timeout pulse -> timeout=0 next cycle.
REQ-034 SHALL cover: zera_timeout asserted on the terminal count cycle -> timeout remains 0 and the counter restarts from 0.
REQ-035 SHALL cover: reset asserted while in FILTRA with botoes=4'b1000 held -> all outputs 0 immediately, then one jogada 7 edges after reset release.

Source files
------------

// File: rtl/detector_jogada.sv
// Debounced one-hot button press detector with an optional sticky timeout counter.
// Define DETECTOR_JOGADA_TIMEOUT_EN to build the timeout counter; otherwise timeout is tied low.
module detector_jogada #(
   parameter int DEBOUNCE_CICLOS = 4,
   parameter int TIMEOUT_CICLOS  = 5000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] botoes,
   input  logic       habilita_timeout,
   input  logic       zera_timeout,
   output logic       jogada,
   output logic [3:0] jogada_codigo,
   output logic       timeout,
   output logic [1:0] db_estado
);

   localparam int DW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
   localparam logic [DW-1:0] DEB_FIM = DW'(DEBOUNCE_CICLOS - 1);

   typedef enum logic [1:0] {
      OCIOSO = 2'd0,
      FILTRA = 2'd1,
      PULSO  = 2'd2,
      SOLTA  = 2'd3
   } estado_t;

   estado_t       estado_reg;
   logic [3:0]    botoes_s;
   logic [3:0]    candidato_reg;
   logic [DW-1:0] deb_cnt_reg;
   logic          candidato_um_quente;

   // Two-flop synchronizer, one independent chain per button.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sinc
         logic meta_reg;
         logic sinc_reg;
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               meta_reg <= 1'b0;
               sinc_reg <= 1'b0;
            end else begin
               meta_reg <= botoes[gi];
               sinc_reg <= meta_reg;
            end
         end
         assign botoes_s[gi] = sinc_reg;
      end
   endgenerate

   assign candidato_um_quente = (candidato_reg != 4'd0) &&
                                ((candidato_reg & (candidato_reg - 4'd1)) == 4'd0);

   // jogada and jogada_codigo are updated on the edge that enters PULSO,
   // so the pulse and the new code are visible exactly while db_estado==PULSO.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_reg    <= OCIOSO;
         candidato_reg <= 4'd0;
         deb_cnt_reg   <= '0;
         jogada        <= 1'b0;
         jogada_codigo <= 4'd0;
      end else begin
         jogada <= 1'b0;
         case (estado_reg)
            OCIOSO: begin
               if (botoes_s != 4'd0) begin
                  candidato_reg <= botoes_s;
                  deb_cnt_reg   <= '0;
                  estado_reg    <= FILTRA;
               end
            end
            FILTRA: begin
               if (botoes_s != candidato_reg) begin
                  estado_reg <= OCIOSO;
               end else if (deb_cnt_reg == DEB_FIM) begin
                  deb_cnt_reg <= '0;
                  if (candidato_um_quente) begin
                     estado_reg    <= PULSO;
                     jogada        <= 1'b1;
                     jogada_codigo <= candidato_reg;
                  end else begin
                     estado_reg <= SOLTA;
                  end
               end else begin
                  deb_cnt_reg <= deb_cnt_reg + DW'(1);
               end
            end
            PULSO: begin
               deb_cnt_reg <= '0;
               estado_reg  <= SOLTA;
            end
            SOLTA: begin
               if (botoes_s != 4'd0) begin
                  deb_cnt_reg <= '0;
               end else if (deb_cnt_reg == DEB_FIM) begin
                  estado_reg <= OCIOSO;
               end else begin
                  deb_cnt_reg <= deb_cnt_reg + DW'(1);
               end
            end
            default: estado_reg <= OCIOSO;
         endcase
      end
   end

   assign db_estado = estado_reg;

`ifdef DETECTOR_JOGADA_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
   localparam logic [TW-1:0] TO_FIM = TW'(TIMEOUT_CICLOS - 1);

   logic [TW-1:0] to_cnt_reg;

   // Clears win over the terminal count; the counter parks at TO_FIM once timeout is set.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         to_cnt_reg <= '0;
         timeout    <= 1'b0;
      end else if (zera_timeout) begin
         to_cnt_reg <= '0;
         timeout    <= 1'b0;
      end else if (jogada) begin
         to_cnt_reg <= '0;
      end else if (habilita_timeout && !timeout) begin
         if (to_cnt_reg == TO_FIM) begin
            timeout <= 1'b1;
         end else begin
            to_cnt_reg <= to_cnt_reg + TW'(1);
         end
      end
   end
`else
   logic unused_entradas_timeout;
   assign unused_entradas_timeout = &{1'b0, habilita_timeout, zera_timeout};
   assign timeout = 1'b0;
`endif

endmodule
